ebus_xfer_ctl: RTL and testbench

Sequences EBOX I/O transfers over the EBUS, and shares the EBUS between two requesters: CON (CONO/CONI/DATAO/DATAI) and PI (interrupt-vector read).
- Drives the EDP EBUS-driver enables (CTL_adToEBUS_L/R), the controller-select and function lines, and the demand/transfer handshake with devices.
- Pulses an AR-load-from-EBUS strobe on reads.
- Sits in the CTL/CON area between the microcode I/O dispatch and the EDP datapath.

---
 rtl/ebus_pkg.sv | 25 ++
 rtl/ebus_xfer_ctl_if.sv | 56 +++++
 rtl/ebus_timer.sv | 27 ++
 rtl/ebus_xfer_ctl.sv | 143 ++++++++++++++
 tb/tb_ebus_xfer_ctl.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ebus_pkg.sv
// Shared EBUS definitions: function encodings, transfer FSM states and
// the write/read classification used by the transfer controller.
package ebus_pkg;

    localparam logic [2:0] FN_CONI  = 3'b000;
    localparam logic [2:0] FN_CONO  = 3'b001;
    localparam logic [2:0] FN_DATAI = 3'b010;
    localparam logic [2:0] FN_DATAO = 3'b011;
    localparam logic [2:0] FN_PIRD  = 3'b100;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_DEMAND  = 3'd2,
        ST_XFER    = 3'd3,
        ST_RELEASE = 3'd4,
        ST_DONE    = 3'd5
    } ebus_state_t;

    // Writes put EDP data on the bus; everything else (including PI) reads.
    function automatic logic isWrite(input logic [2:0] func);
        return (func == FN_CONO) || (func == FN_DATAO);
    endfunction

endpackage

// File: rtl/ebus_xfer_ctl_if.sv
// EBUS transfer interface: requester inputs, device acknowledge and all
// controller outputs. With EBUS_PARITY_EN defined it also carries the
// returned bus data, its parity bit and the parity-error pulse.
//
// Handshake: CON_ioReq / PI_req are levels. A requester raises its request
// and holds it (with stable dev/func) until it sees a one-cycle ioDone or
// ioTimeout; the controller samples requests only while idle. On the device
// side ebusDemand is held until EBUS_xfer is seen high, and the transfer
// then waits for EBUS_xfer to fall before completing.
interface ebus_xfer_ctl_if
    import ebus_pkg::*;
#(
    parameter int CS_WIDTH = 7
);
    logic                CON_ioReq;
    logic [1:0]          CON_ioFunc;
    logic [CS_WIDTH-1:0] CON_ioDev;
    logic                PI_req;
    logic [CS_WIDTH-1:0] PI_dev;
    logic                EBUS_xfer;
`ifdef EBUS_PARITY_EN
    logic [0:35]         EBUS_data;
    logic                EBUS_parity;
    logic                ioParityErr;
`endif
    logic [CS_WIDTH-1:0] ebusCS;
    logic [2:0]          ebusFunc;
    logic                ebusDemand;
    logic                CTL_adToEBUS_L;
    logic                CTL_adToEBUS_R;
    logic                ebusToAR;
    logic                ioBusy;
    logic                grantPI;
    logic                ioDone;
    logic                ioTimeout;
    ebus_state_t         dbg_state;

    modport slave (
`ifdef EBUS_PARITY_EN
        input  EBUS_data, input EBUS_parity, output ioParityErr,
`endif
        input  CON_ioReq, CON_ioFunc, CON_ioDev, PI_req, PI_dev, EBUS_xfer,
        output ebusCS, ebusFunc, ebusDemand, CTL_adToEBUS_L, CTL_adToEBUS_R,
        output ebusToAR, ioBusy, grantPI, ioDone, ioTimeout, dbg_state
    );

    modport master (
`ifdef EBUS_PARITY_EN
        output EBUS_data, output EBUS_parity, input ioParityErr,
`endif
        output CON_ioReq, CON_ioFunc, CON_ioDev, PI_req, PI_dev, EBUS_xfer,
        input  ebusCS, ebusFunc, ebusDemand, CTL_adToEBUS_L, CTL_adToEBUS_R,
        input  ebusToAR, ioBusy, grantPI, ioDone, ioTimeout, dbg_state
    );

endinterface

// File: rtl/ebus_timer.sv
// Loadable down-counter. expired is high whenever the count sits at zero;
// the count holds at zero until reloaded.
module ebus_timer #(
    parameter int WIDTH = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             expired
);
    logic [WIDTH-1:0] count_q;

    // Load takes priority; otherwise count down and stop at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign expired = (count_q == '0);

endmodule

// File: rtl/ebus_xfer_ctl.sv
// EBUS transfer controller: arbitrates CON and PI requests (PI first),
// sequences SETUP/DEMAND/XFER/RELEASE/DONE and decodes Moore outputs from
// the registered state plus a grant/func/dev latch. One ebus_timer serves
// both the setup count and the DEMAND/RELEASE timeout.
// Optional build macro: EBUS_PARITY_EN (odd-parity check on read data).
module ebus_xfer_ctl
    import ebus_pkg::*;
#(
    parameter int SETUP_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CS_WIDTH       = 7
) (
    input logic            eboxClk,
    input logic            eboxReset,
    ebus_xfer_ctl_if.slave bus
);
    localparam int MAX_CNT = (TIMEOUT_CYCLES > SETUP_CYCLES) ? TIMEOUT_CYCLES : SETUP_CYCLES;
    localparam int TW      = $clog2(MAX_CNT) + 1;
    localparam logic [TW-1:0] SETUP_LOAD   = TW'(SETUP_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LOAD = TW'(TIMEOUT_CYCLES - 1);

    ebus_state_t         state_q, state_d;
    logic                grant_q;
    logic [2:0]          func_q;
    logic [CS_WIDTH-1:0] dev_q;
    logic                timed_out_q;
    logic                latch_en, set_timeout;
    logic                tmr_load, tmr_expired;
    logic [TW-1:0]       tmr_val;
    logic                in_xact, write_xact;

    ebus_timer #(.WIDTH(TW)) u_timer (
        .clk      (eboxClk),
        .rst      (eboxReset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (tmr_expired)
    );

    // State register.
    always_ff @(posedge eboxClk) begin
        if (eboxReset) state_q <= ST_IDLE;
        else           state_q <= state_d;
    end

    // Next state, timer reloads and request latch enable.
    always_comb begin
        state_d     = state_q;
        latch_en    = 1'b0;
        set_timeout = 1'b0;
        tmr_load    = 1'b0;
        tmr_val     = '0;
        case (state_q)
            ST_IDLE: begin
                if (bus.PI_req || bus.CON_ioReq) begin
                    state_d  = ST_SETUP;
                    latch_en = 1'b1;
                    tmr_load = 1'b1;
                    tmr_val  = SETUP_LOAD;
                end
            end
            ST_SETUP: begin
                if (tmr_expired) begin
                    state_d  = ST_DEMAND;
                    tmr_load = 1'b1;
                    tmr_val  = TIMEOUT_LOAD;
                end
            end
            ST_DEMAND: begin
                if (bus.EBUS_xfer) begin
                    state_d = ST_XFER;
                end else if (tmr_expired) begin
                    state_d     = ST_DONE;
                    set_timeout = 1'b1;
                end
            end
            ST_XFER: begin
                state_d  = ST_RELEASE;
                tmr_load = 1'b1;
                tmr_val  = TIMEOUT_LOAD;
            end
            ST_RELEASE: begin
                if (!bus.EBUS_xfer) begin
                    state_d = ST_DONE;
                end else if (tmr_expired) begin
                    state_d     = ST_DONE;
                    set_timeout = 1'b1;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Winner's grant/func/dev latch and the timeout-vs-done outcome flag.
    always_ff @(posedge eboxClk) begin
        if (eboxReset) begin
            grant_q     <= 1'b0;
            func_q      <= '0;
            dev_q       <= '0;
            timed_out_q <= 1'b0;
        end else if (latch_en) begin
            grant_q     <= bus.PI_req;
            func_q      <= bus.PI_req ? FN_PIRD : {1'b0, bus.CON_ioFunc};
            dev_q       <= bus.PI_req ? bus.PI_dev : bus.CON_ioDev;
            timed_out_q <= 1'b0;
        end else if (set_timeout) begin
            timed_out_q <= 1'b1;
        end
    end

    assign in_xact    = (state_q == ST_SETUP) || (state_q == ST_DEMAND) ||
                        (state_q == ST_XFER)  || (state_q == ST_RELEASE);
    assign write_xact = isWrite(func_q);

    assign bus.ebusCS         = in_xact ? dev_q  : '0;
    assign bus.ebusFunc       = in_xact ? func_q : '0;
    assign bus.grantPI        = in_xact && grant_q;
    assign bus.ebusDemand     = (state_q == ST_DEMAND) || (state_q == ST_XFER);
    assign bus.CTL_adToEBUS_L = write_xact && (in_xact && state_q != ST_RELEASE);
    assign bus.CTL_adToEBUS_R = write_xact && (in_xact && state_q != ST_RELEASE);
    assign bus.ebusToAR       = (state_q == ST_XFER) && !write_xact;
    assign bus.ioBusy         = (state_q != ST_IDLE);
    assign bus.ioDone         = (state_q == ST_DONE) && !timed_out_q;
    assign bus.ioTimeout      = (state_q == ST_DONE) && timed_out_q;
    assign bus.dbg_state      = state_q;

`ifdef EBUS_PARITY_EN
    logic parity_err_q;

    // Capture the odd-parity result of read data in XFER; reported in DONE.
    always_ff @(posedge eboxClk) begin
        if (eboxReset || latch_en) begin
            parity_err_q <= 1'b0;
        end else if (state_q == ST_XFER && !write_xact) begin
            parity_err_q <= ~^{bus.EBUS_data, bus.EBUS_parity};
        end
    end

    assign bus.ioParityErr = (state_q == ST_DONE) && !timed_out_q && parity_err_q;
`endif

endmodule

// File: tb/tb_ebus_xfer_ctl.sv
// Bench for ebus_xfer_ctl: directed transfers with hand-computed per-transfer
// summaries pushed into exp_q; a negedge monitor builds the observed summary
// of each transfer and compares it when ioDone/ioTimeout appears.
module tb_ebus_xfer_ctl;
    import ebus_pkg::*;

    localparam int CSW   = 7;
    localparam int SETUP = 2;
    localparam int TMO   = 16;
    localparam int W     = 49;

    logic eboxClk = 1'b0;
    logic eboxReset;

    always #5 eboxClk = ~eboxClk;

    ebus_xfer_ctl_if #(.CS_WIDTH(CSW)) bus ();

    ebus_xfer_ctl #(
        .SETUP_CYCLES   (SETUP),
        .TIMEOUT_CYCLES (TMO),
        .CS_WIDTH       (CSW)
    ) dut (
        .eboxClk   (eboxClk),
        .eboxReset (eboxReset),
        .bus       (bus)
    );

    logic [W-1:0] exp_q[$];
    int tests_run    = 0;
    int tests_failed = 0;
    int ack_dly      = 1;
    int rel_dly      = 1;
    logic done_pe    = 1'b0;

    // Summary: {clean_done, busy, drv_and, drv_or, demand, to_ar, cs, func, grant, timeout}
    function automatic logic [W-1:0] pack(input logic clean, input int busy, input int drva,
                                          input int drvo, input int dem, input int ar,
                                          input logic [6:0] cs, input logic [2:0] fn,
                                          input logic g, input logic to);
        logic [7:0] b8, da8, do8, dm8;
        logic [3:0] ar4;
        b8 = busy[7:0]; da8 = drva[7:0]; do8 = drvo[7:0]; dm8 = dem[7:0]; ar4 = ar[3:0];
        return {clean, b8, da8, do8, dm8, ar4, cs, fn, g, to};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Device model: raises EBUS_xfer after ack_dly demand cycles (0 = already
    // high, negative = never) and drops it rel_dly cycles after demand falls.
    initial begin
        int dcnt, rcnt;
        logic seen;
        dcnt = 0; rcnt = 0; seen = 1'b0;
        bus.EBUS_xfer = 1'b0;
        forever begin
            @(negedge eboxClk);
            if (ack_dly < 0) begin
                bus.EBUS_xfer = 1'b0;
            end else if (!bus.ioBusy) begin
                dcnt = 0; rcnt = 0; seen = 1'b0;
                bus.EBUS_xfer = (ack_dly == 0);
            end else if (bus.ebusDemand) begin
                seen = 1'b1;
                dcnt++;
                if (dcnt >= ack_dly) bus.EBUS_xfer = 1'b1;
            end else if (seen) begin
                rcnt++;
                if (rcnt >= rel_dly) bus.EBUS_xfer = 1'b0;
            end
        end
    end

    // Monitor: accumulate one transfer's observations, compare on completion.
    initial begin
        logic active, clean;
        int busy_c, dem_c, drvo_c, drva_c, ar_c;
        logic [6:0] cs_c;
        logic [2:0] f_c;
        logic g_c;
        logic [W-1:0] obs, e;
        active = 1'b0;
        busy_c = 0; dem_c = 0; drvo_c = 0; drva_c = 0; ar_c = 0;
        cs_c = '0; f_c = '0; g_c = 1'b0;
        forever begin
            @(negedge eboxClk);
            if (eboxReset) begin
                active = 1'b0;
            end else if (bus.ioBusy) begin
                if (!active) begin
                    active = 1'b1;
                    busy_c = 0; dem_c = 0; drvo_c = 0; drva_c = 0; ar_c = 0;
                    cs_c = bus.ebusCS; f_c = bus.ebusFunc; g_c = bus.grantPI;
                end
                busy_c++;
                dem_c  += int'(bus.ebusDemand);
                drvo_c += int'(bus.CTL_adToEBUS_L | bus.CTL_adToEBUS_R);
                drva_c += int'(bus.CTL_adToEBUS_L & bus.CTL_adToEBUS_R);
                ar_c   += int'(bus.ebusToAR);
                if (bus.ioDone || bus.ioTimeout) begin
                    clean = (bus.ebusCS == '0) && (bus.ebusFunc == '0) && !bus.grantPI &&
                            !(bus.ioDone && bus.ioTimeout) && !bus.ebusDemand &&
                            !bus.CTL_adToEBUS_L && !bus.CTL_adToEBUS_R;
                    obs = pack(clean, busy_c, drva_c, drvo_c, dem_c, ar_c, cs_c, f_c, g_c,
                               bus.ioTimeout);
                    tests_run++;
                    if (exp_q.size() == 0) begin
                        tests_failed++;
                        $display("FAIL unexpected_done: got %0h expected none", obs);
                    end else begin
                        e = exp_q.pop_front();
                        if (obs !== e) begin
                            tests_failed++;
                            $display("FAIL xfer_summary: got %0h expected %0h", obs, e);
                        end
                    end
                    active = 1'b0;
                end
            end
        end
    end

    task automatic wait_done();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge eboxClk); #1;
            if (bus.ioDone || bus.ioTimeout) begin
                ok = 1'b1;
`ifdef EBUS_PARITY_EN
                done_pe = bus.ioParityErr;
`endif
                break;
            end
        end
        if (!ok) begin
            tests_run++;
            tests_failed++;
            $display("FAIL wait_done: got no completion expected ioDone or ioTimeout");
        end
    endtask

    task automatic issue(input logic pi, input logic [1:0] fn, input logic [6:0] dev,
                         input int ack, input int rel, input logic [W-1:0] e);
        ack_dly = ack;
        rel_dly = rel;
        exp_q.push_back(e);
        if (pi) begin
            bus.PI_dev = dev;
            bus.PI_req = 1'b1;
        end else begin
            bus.CON_ioFunc = fn;
            bus.CON_ioDev  = dev;
            bus.CON_ioReq  = 1'b1;
        end
    endtask

    task automatic run_xfer(input logic pi, input logic [1:0] fn, input logic [6:0] dev,
                            input int ack, input int rel, input logic [W-1:0] e);
        issue(pi, fn, dev, ack, rel, e);
        wait_done();
        bus.PI_req    = 1'b0;
        bus.CON_ioReq = 1'b0;
        @(posedge eboxClk); #1;
    endtask

    initial begin
        eboxReset      = 1'b1;
        bus.CON_ioReq  = 1'b0;
        bus.CON_ioFunc = 2'd0;
        bus.CON_ioDev  = '0;
        bus.PI_req     = 1'b0;
        bus.PI_dev     = '0;
`ifdef EBUS_PARITY_EN
        bus.EBUS_data   = '0;
        bus.EBUS_parity = 1'b1;
`endif
        repeat (3) @(posedge eboxClk);
        #1;
        check("reset_outputs",
              {bus.ioBusy, bus.ebusDemand, bus.ebusCS, bus.ebusFunc, bus.grantPI,
               bus.CTL_adToEBUS_L, bus.CTL_adToEBUS_R, bus.ebusToAR, bus.ioDone, bus.ioTimeout},
              64'd0);
        eboxReset = 1'b0;
        @(posedge eboxClk); #1;

        // CONO 004, ack after one demand cycle, release after two.
        run_xfer(1'b0, 2'd1, 7'o004, 1, 2, pack(1'b1, 7, 4, 4, 2, 0, 7'o004, 3'd1, 1'b0, 1'b0));
        // DATAI 070 with EBUS_xfer already high.
        run_xfer(1'b0, 2'd2, 7'o070, 0, 1, pack(1'b1, 6, 0, 0, 2, 1, 7'o070, 3'd2, 1'b0, 1'b0));

        // PI and CON together: PI first, CON starts right after the idle cycle.
        issue(1'b1, 2'd0, 7'o012, 1, 1, pack(1'b1, 6, 0, 0, 2, 1, 7'o012, 3'd4, 1'b1, 1'b0));
        issue(1'b0, 2'd0, 7'o030, 1, 1, pack(1'b1, 6, 0, 0, 2, 1, 7'o030, 3'd0, 1'b0, 1'b0));
        wait_done();
        bus.PI_req = 1'b0;
        @(posedge eboxClk); #1;
        check("idle_between", {63'd0, bus.ioBusy}, 64'd0);
        @(posedge eboxClk); #1;
        check("con_follows", {bus.ioBusy, bus.grantPI, bus.ebusFunc, bus.ebusCS},
              {1'b1, 1'b0, 3'd0, 7'o030});
        wait_done();
        bus.CON_ioReq = 1'b0;
        @(posedge eboxClk); #1;

        // DATAO 100, never acknowledged: 16 demand cycles then timeout.
        run_xfer(1'b0, 2'd3, 7'o100, -1, 1, pack(1'b1, 19, 18, 18, 16, 0, 7'o100, 3'd3, 1'b0, 1'b1));
        // CONI 055, EBUS_xfer never released: timeout out of RELEASE.
        run_xfer(1'b0, 2'd0, 7'o055, 1, 50, pack(1'b1, 21, 0, 0, 2, 1, 7'o055, 3'd0, 1'b0, 1'b1));
        // DATAO 177, slow ack and slow release.
        run_xfer(1'b0, 2'd3, 7'o177, 3, 3, pack(1'b1, 10, 6, 6, 4, 0, 7'o177, 3'd3, 1'b0, 1'b0));

        // Reset while in DEMAND abandons the transfer silently.
        ack_dly = -1;
        bus.CON_ioFunc = 2'd1;
        bus.CON_ioDev  = 7'o005;
        bus.CON_ioReq  = 1'b1;
        begin
            logic seen_dem;
            seen_dem = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(posedge eboxClk); #1;
                if (bus.ebusDemand) begin
                    seen_dem = 1'b1;
                    break;
                end
            end
            check("reach_demand", {63'd0, seen_dem}, 64'd1);
        end
        eboxReset     = 1'b1;
        bus.CON_ioReq = 1'b0;
        @(posedge eboxClk); #1;
        check("reset_mid",
              {bus.ioBusy, bus.ebusDemand, bus.ebusCS, bus.ebusFunc, bus.grantPI,
               bus.CTL_adToEBUS_L, bus.CTL_adToEBUS_R, bus.ebusToAR, bus.ioDone, bus.ioTimeout},
              64'd0);
        eboxReset = 1'b0;
        @(posedge eboxClk); #1;
        run_xfer(1'b0, 2'd1, 7'o001, 1, 1, pack(1'b1, 6, 4, 4, 2, 0, 7'o001, 3'd1, 1'b0, 1'b0));

`ifdef EBUS_PARITY_EN
        // Read data 36'o1 with parity 1: even total, flagged.
        bus.EBUS_data   = 36'o1;
        bus.EBUS_parity = 1'b1;
        run_xfer(1'b0, 2'd0, 7'o011, 1, 1, pack(1'b1, 6, 0, 0, 2, 1, 7'o011, 3'd0, 1'b0, 1'b0));
        check("parity_bad", {63'd0, done_pe}, 64'd1);
        // Same data with parity 0: odd total, clean.
        bus.EBUS_parity = 1'b0;
        run_xfer(1'b0, 2'd0, 7'o011, 1, 1, pack(1'b1, 6, 0, 0, 2, 1, 7'o011, 3'd0, 1'b0, 1'b0));
        check("parity_good", {63'd0, done_pe}, 64'd0);
`endif

        repeat (4) @(posedge eboxClk);
        #1;
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
